// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; one transaction in flight.
// Optional fetch starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_gnt,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,

    output logic                busy
);

    localparam int unsigned BeW = DATA_W / 8;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("STARVE_MAX must be in 1..15");
    end

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    localparam logic OwnerIf = 1'b0;
    localparam logic OwnerD  = 1'b1;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                kill_q, kill_d;
    logic                m_we_q, m_we_d;
    logic [BeW-1:0]      m_be_q, m_be_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic force_if;
    logic idle;
    logic d_win;
    logic if_win;

    assign idle = (state_q == StIdle);

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign force_if = (starve_cnt_q == StarveMax);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (idle) begin
            if (if_gnt || !if_req) begin
                starve_cnt_d = 4'd0;
            end else if (d_gnt && (starve_cnt_q != StarveMax)) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    // Grants are suppressed during reset so every output reads 0 while rst is high.
    assign d_win  = !rst && idle && d_req && !(if_req && force_if);
    assign if_win = !rst && idle && if_req && !d_win;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        kill_d      = kill_q;
        m_we_d      = m_we_q;
        m_be_d      = m_be_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;

        unique case (state_q)
            StIdle: begin
                kill_d = 1'b0;
                if (d_win) begin
                    d_gnt     = 1'b1;
                    owner_d   = OwnerD;
                    m_we_d    = d_we;
                    m_be_d    = d_be;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    state_d   = StReq;
                end else if (if_win) begin
                    if_gnt    = 1'b1;
                    owner_d   = OwnerIf;
                    m_we_d    = 1'b0;
                    m_be_d    = '1;
                    m_addr_d  = if_addr;
                    m_wdata_d = '0;
                    kill_d    = if_flush;
                    state_d   = StReq;
                end
            end

            // A response arriving before the grant is a protocol error and is dropped.
            StReq: begin
                if (if_flush && (owner_q == OwnerIf)) begin
                    kill_d = 1'b1;
                end
                if (m_gnt) begin
                    state_d = StWait;
                end
            end

            StWait: begin
                if (m_rvalid) begin
                    state_d = StIdle;
                    kill_d  = 1'b0;
                    if (owner_q == OwnerD) begin
                        d_rvalid_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdata_d = m_rdata;
                        end
                    end else if (!(kill_q || if_flush)) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = m_rdata;
                    end
                end else if (if_flush && (owner_q == OwnerIf)) begin
                    kill_d = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= OwnerIf;
            kill_q      <= 1'b0;
            m_we_q      <= 1'b0;
            m_be_q      <= '0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            kill_q      <= kill_d;
            m_we_q      <= m_we_d;
            m_be_q      <= m_be_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign m_req     = (state_q == StReq);
    assign m_we      = m_we_q;
    assign m_be      = m_be_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = !idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store backpressure, conflict, starvation, flush,
// reset mid-transaction.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_gnt, m_rvalid;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_if_pulses = 0;
    int n_d_pulses = 0;
    int dgr;
    logic seen_if;

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_be     (m_be),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (if_rvalid) n_if_pulses++;
        if (d_rvalid)  n_d_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call one cycle into REQ; returns in the cycle where the owner's rvalid is visible.
    task automatic do_mem(input int gnt_delay, input logic [31:0] rdata);
        for (int i = 0; i < gnt_delay; i++) begin
            m_gnt = 1'b0;
            #1;
            check_eq("m_req_hold", 64'(m_req), 64'd1);
            step();
        end
        m_gnt = 1'b1;
        #1;
        check_eq("m_req_gnt", 64'(m_req), 64'd1);
        step();
        m_gnt    = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = rdata;
        #1;
        check_eq("m_req_wait", 64'(m_req), 64'd0);
        step();
        m_rvalid = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        step();
        step();
        if_req = 1'b1;
        d_req  = 1'b1;
        #1;
        check_eq("rst_if_gnt", 64'(if_gnt), 64'd0);
        check_eq("rst_d_gnt", 64'(d_gnt), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_m_req", 64'(m_req), 64'd0);
        check_eq("rst_rvalids", 64'({if_rvalid, d_rvalid}), 64'd0);
        if_req = 1'b0;
        d_req  = 1'b0;
        rst    = 1'b0;
        step();

        // Single fetch
        if_req  = 1'b1;
        if_addr = 32'h100;
        #1;
        check_eq("t1_if_gnt", 64'(if_gnt), 64'd1);
        check_eq("t1_d_gnt", 64'(d_gnt), 64'd0);
        step();
        if_req = 1'b0;
        #1;
        check_eq("t1_m_req", 64'(m_req), 64'd1);
        check_eq("t1_m_addr", 64'(m_addr), 64'h100);
        check_eq("t1_m_we_be", 64'({m_we, m_be}), 64'h0F);
        check_eq("t1_busy", 64'(busy), 64'd1);
        do_mem(0, 32'h0050_0093);
        check_eq("t1_if_rvalid", 64'(if_rvalid), 64'd1);
        check_eq("t1_if_rdata", 64'(if_rdata), 64'h0050_0093);
        check_eq("t1_d_rvalid", 64'(d_rvalid), 64'd0);
        check_eq("t1_busy_idle", 64'(busy), 64'd0);
        step();
        check_eq("t1_if_rvalid_end", 64'(if_rvalid), 64'd0);

        // Store with memory backpressure; a stray flush must not affect the data owner
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'h3;
        d_addr  = 32'h200;
        d_wdata = 32'hBEEF;
        #1;
        check_eq("t2_d_gnt", 64'(d_gnt), 64'd1);
        step();
        d_req = 1'b0;
        d_we  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_gnt = (i == 3);
            #1;
            check_eq("t2_m_req", 64'(m_req), 64'd1);
            check_eq("t2_m_addr", 64'(m_addr), 64'h200);
            check_eq("t2_m_wdata", 64'(m_wdata), 64'hBEEF);
            check_eq("t2_m_we_be", 64'({m_we, m_be}), 64'h13);
            step();
        end
        m_gnt    = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 32'hDEAD_BEEF;
        if_flush = 1'b1;
        #1;
        check_eq("t2_m_req_wait", 64'(m_req), 64'd0);
        step();
        m_rvalid = 1'b0;
        if_flush = 1'b0;
        #1;
        check_eq("t2_d_rvalid", 64'(d_rvalid), 64'd1);
        check_eq("t2_d_rdata_kept", 64'(d_rdata), 64'd0);
        check_eq("t2_if_rvalid", 64'(if_rvalid), 64'd0);
        step();
        check_eq("t2_d_rvalid_end", 64'(d_rvalid), 64'd0);

        // Conflict: data wins, fetch follows in the IDLE cycle with d_rvalid
        if_req  = 1'b1;
        if_addr = 32'h300;
        d_req   = 1'b1;
        d_addr  = 32'h400;
        d_be    = 4'hF;
        #1;
        check_eq("t3_d_gnt", 64'(d_gnt), 64'd1);
        check_eq("t3_if_gnt", 64'(if_gnt), 64'd0);
        step();
        d_req = 1'b0;
        #1;
        check_eq("t3_m_addr_d", 64'(m_addr), 64'h400);
        check_eq("t3_if_gnt_busy", 64'(if_gnt), 64'd0);
        do_mem(0, 32'h1111_2222);
        check_eq("t3_d_rvalid", 64'(d_rvalid), 64'd1);
        check_eq("t3_d_rdata", 64'(d_rdata), 64'h1111_2222);
        check_eq("t3_if_gnt_late", 64'(if_gnt), 64'd1);
        step();
        if_req = 1'b0;
        #1;
        check_eq("t3_m_addr_if", 64'(m_addr), 64'h300);
        do_mem(0, 32'h3333_4444);
        check_eq("t3_if_rvalid", 64'(if_rvalid), 64'd1);
        check_eq("t3_if_rdata", 64'(if_rdata), 64'h3333_4444);
        step();

        // Starvation: fetch held, data re-requested every IDLE
        dgr     = 0;
        seen_if = 1'b0;
        if_addr = 32'h5000;
        for (int i = 0; i < 8 && !seen_if; i++) begin
            if_req = 1'b1;
            d_req  = 1'b1;
            d_addr = 32'h500 + 32'(i * 4);
            #1;
            if (if_gnt) seen_if = 1'b1;
            else if (d_gnt) dgr++;
            step();
            d_req = 1'b0;
            do_mem(0, 32'h1000 + 32'(i));
        end
`ifdef ARB_STARVE_GUARD_EN
        check_eq("t4_data_grants", 64'(dgr), 64'd4);
        check_eq("t4_if_forced", 64'(seen_if), 64'd1);
`else
        check_eq("t4_data_grants", 64'(dgr), 64'd8);
        check_eq("t4_if_starved", 64'(seen_if), 64'd0);
`endif
        d_req  = 1'b1;
        d_addr = 32'h5F0;
        #1;
        check_eq("t4_d_again", 64'(d_gnt), 64'd1);
        check_eq("t4_if_not_again", 64'(if_gnt), 64'd0);
        step();
        d_req = 1'b0;
        do_mem(0, 32'h7777);
        check_eq("t4_if_gnt_after", 64'(if_gnt), 64'd1);
        step();
        if_req = 1'b0;
        do_mem(0, 32'hA5A5_A5A5);
        check_eq("t4_if_rvalid", 64'(if_rvalid), 64'd1);
        check_eq("t4_if_rdata", 64'(if_rdata), 64'hA5A5_A5A5);
        step();

        // Flush during WAIT suppresses if_rvalid, next fetch is normal
        if_req  = 1'b1;
        if_addr = 32'h600;
        #1;
        check_eq("t5_if_gnt", 64'(if_gnt), 64'd1);
        step();
        if_req = 1'b0;
        m_gnt  = 1'b1;
        step();
        m_gnt    = 1'b0;
        if_flush = 1'b1;
        step();
        if_flush = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 32'h5555_AAAA;
        step();
        m_rvalid = 1'b0;
        #1;
        check_eq("t5_if_rvalid_killed", 64'(if_rvalid), 64'd0);
        check_eq("t5_busy", 64'(busy), 64'd0);
        if_req  = 1'b1;
        if_addr = 32'h700;
        #1;
        check_eq("t5_if_gnt_next", 64'(if_gnt), 64'd1);
        step();
        if_req = 1'b0;
        do_mem(1, 32'hCAFE_F00D);
        check_eq("t5_if_rvalid_next", 64'(if_rvalid), 64'd1);
        check_eq("t5_if_rdata_next", 64'(if_rdata), 64'hCAFE_F00D);
        step();

        // Reset mid-transaction, then a late response
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h800;
        #1;
        step();
        d_req = 1'b0;
        m_gnt = 1'b1;
        #1;
        step();
        m_gnt = 1'b0;
        rst   = 1'b1;
        step();
        check_eq("t6_busy", 64'(busy), 64'd0);
        check_eq("t6_m_req", 64'(m_req), 64'd0);
        check_eq("t6_m_addr", 64'(m_addr), 64'd0);
        check_eq("t6_rdata", 64'({if_rdata, d_rdata}), 64'd0);
        rst      = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 32'h99;
        #1;
        check_eq("t6_busy_late", 64'(busy), 64'd0);
        step();
        m_rvalid = 1'b0;
        #1;
        check_eq("t6_no_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
        d_req  = 1'b1;
        d_addr = 32'h900;
        #1;
        check_eq("t6_d_gnt", 64'(d_gnt), 64'd1);
        step();
        d_req = 1'b0;
        #1;
        check_eq("t6_m_addr_new", 64'(m_addr), 64'h900);
        do_mem(0, 32'h1234_5678);
        check_eq("t6_d_rvalid", 64'(d_rvalid), 64'd1);
        check_eq("t6_d_rdata", 64'(d_rdata), 64'h1234_5678);
        step();
        step();

`ifdef ARB_STARVE_GUARD_EN
        check_eq("total_if_pulses", 64'(n_if_pulses), 64'd5);
        check_eq("total_d_pulses", 64'(n_d_pulses), 64'd8);
`else
        check_eq("total_if_pulses", 64'(n_if_pulses), 64'd4);
        check_eq("total_d_pulses", 64'(n_d_pulses), 64'd12);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
